// File: rtl/amm_trans_block_pkg.sv
// Shared widths, the operation packet layout and burst-length helper for the
// memory checker's Avalon-MM transaction block.
package amm_trans_block_pkg;

    localparam int AMM_DATA_W  = 64;
    localparam int AMM_ADDR_W  = 28;
    localparam int AMM_BURST_W = 11;
    localparam int BYTE_ADDR_W = $clog2(AMM_DATA_W / 8);

    typedef logic [AMM_BURST_W:0] burst_len_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_type_e;

    typedef struct packed {
        logic [AMM_ADDR_W-1:0]  word_address;
        logic [AMM_BURST_W-1:0] high_burst_bits;
        logic [AMM_BURST_W-1:0] low_burst_bits;
        logic [BYTE_ADDR_W-1:0] start_offset;
        logic [BYTE_ADDR_W-1:0] end_offset;
    } trans_struct_type;

    // The burst length is split across two fields; an empty packet still moves one word.
    function automatic burst_len_t burst_len(input trans_struct_type pkt);
        burst_len_t n;
        n = burst_len_t'(pkt.high_burst_bits) + burst_len_t'(pkt.low_burst_bits);
        return (n == '0) ? burst_len_t'(1) : n;
    endfunction

endpackage

// File: rtl/amm_trans_block_if.sv
// Command, Avalon-MM and read-forwarding signals of the transaction block.
// master is the transaction block's view, slave is its environment.
interface amm_trans_block_if
    import amm_trans_block_pkg::*;
#(
    parameter int DATA_W = AMM_DATA_W
);

    localparam int BE_W = DATA_W / 8;

    logic                   op_valid_i;
    logic                   op_type_i;
    trans_struct_type       op_pkt_i;
    logic                   cmd_accept_ready_o;
    logic                   trans_block_busy_o;

    logic [AMM_ADDR_W-1:0]  amm_address_o;
    logic                   amm_write_o;
    logic                   amm_read_o;
    logic [DATA_W-1:0]      amm_writedata_o;
    logic [BE_W-1:0]        amm_byteenable_o;
    logic [AMM_BURST_W-1:0] amm_burstcount_o;
    logic                   amm_waitrequest_i;
    logic                   amm_readdatavalid_i;
    logic [DATA_W-1:0]      amm_readdata_i;

    logic                   rd_data_valid_o;
    logic [DATA_W-1:0]      rd_data_o;
    logic [AMM_ADDR_W-1:0]  rd_addr_o;
    logic [BE_W-1:0]        rd_byteenable_o;

    modport master (
        input  op_valid_i, op_type_i, op_pkt_i,
        input  amm_waitrequest_i, amm_readdatavalid_i, amm_readdata_i,
        output cmd_accept_ready_o, trans_block_busy_o,
        output amm_address_o, amm_write_o, amm_read_o, amm_writedata_o,
        output amm_byteenable_o, amm_burstcount_o,
        output rd_data_valid_o, rd_data_o, rd_addr_o, rd_byteenable_o
    );

    modport slave (
        output op_valid_i, op_type_i, op_pkt_i,
        output amm_waitrequest_i, amm_readdatavalid_i, amm_readdata_i,
        input  cmd_accept_ready_o, trans_block_busy_o,
        input  amm_address_o, amm_write_o, amm_read_o, amm_writedata_o,
        input  amm_byteenable_o, amm_burstcount_o,
        input  rd_data_valid_o, rd_data_o, rd_addr_o, rd_byteenable_o
    );

endinterface

// File: rtl/amm_trans_block_byte_mask_gen.sv
// Lane-enable mask for one beat of a burst: the first beat starts at
// start_offset, the last beat stops at end_offset, middle beats are full.
module byte_mask_gen
    import amm_trans_block_pkg::*;
#(
    parameter  int DATA_W = AMM_DATA_W,
    localparam int BE_W   = DATA_W / 8,
    localparam int LB_W   = $clog2(BE_W)
) (
    input  burst_len_t      beat_i,
    input  burst_len_t      n_i,
    input  logic [LB_W-1:0] start_offset_i,
    input  logic [LB_W-1:0] end_offset_i,
    output logic [BE_W-1:0] byteenable_o
);

    logic first_beat;
    logic last_beat;

    assign first_beat = (beat_i == '0);
    assign last_beat  = (beat_i == n_i - burst_len_t'(1));

    always_comb begin
        byteenable_o = '0;
        for (int k = 0; k < BE_W; k++) begin
            byteenable_o[k] = (!first_beat || (k >= int'(start_offset_i))) &&
                              (!last_beat  || (k <= int'(end_offset_i)));
        end
    end

endmodule

// File: rtl/amm_trans_block.sv
// Turns accepted operation packets into single Avalon-MM write or read bursts
// and forwards returned read beats, tagged with address and lanes, downstream.
module amm_trans_block
    import amm_trans_block_pkg::*;
#(
    parameter int DATA_W = AMM_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    amm_trans_block_if.master bus
);

    localparam int BE_W = DATA_W / 8;
    localparam int LB_W = $clog2(BE_W);

    typedef enum logic [1:0] {
        IDLE_S,
        WRITE_S,
        READ_CMD_S,
        READ_DATA_S
    } state_e;

    state_e                 state_q, state_d;
    logic [AMM_ADDR_W-1:0]  waddr_q, waddr_d;
    logic [LB_W-1:0]        start_q, start_d;
    logic [LB_W-1:0]        end_q, end_d;
    burst_len_t             n_q, n_d;
    burst_len_t             beat_q, beat_d;
    burst_len_t             rd_cnt_q, rd_cnt_d;

    logic                   write_q, write_d;
    logic                   read_q, read_d;
    logic [AMM_ADDR_W-1:0]  addr_q, addr_d;
    logic [AMM_BURST_W-1:0] burst_q, burst_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [BE_W-1:0]        be_q, be_d;

    logic                   rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]      rd_data_q, rd_data_d;
    logic [AMM_ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [BE_W-1:0]        rd_be_q, rd_be_d;

    logic                   idle;
    burst_len_t             acc_n;
    burst_len_t             wr_beat;
    burst_len_t             wr_n;
    logic [LB_W-1:0]        wr_start;
    logic [LB_W-1:0]        wr_end;
    logic [7:0]             wr_word_lsb;
    logic [DATA_W-1:0]      wr_data;
    logic [BE_W-1:0]        wr_be;
    logic [BE_W-1:0]        rd_be;

    // Only the low address byte matters: each data byte is its own byte address mod 256.
    function automatic logic [DATA_W-1:0] pattern_word(input logic [7:0] word_lsb);
        logic [7:0] first_byte;
        pattern_word = '0;
        first_byte   = word_lsb * 8'(BE_W);
        for (int k = 0; k < BE_W; k++) begin
            pattern_word[8*k +: 8] = first_byte + 8'(k);
        end
    endfunction

    assign idle  = (state_q == IDLE_S);
    assign acc_n = burst_len(bus.op_pkt_i);

    // While idle the write path prepares beat 0 of the incoming packet; during a
    // burst it prepares the beat after the one currently on the bus.
    always_comb begin
        wr_beat     = idle ? '0 : beat_q + burst_len_t'(1);
        wr_n        = idle ? acc_n : n_q;
        wr_start    = idle ? bus.op_pkt_i.start_offset[LB_W-1:0] : start_q;
        wr_end      = idle ? bus.op_pkt_i.end_offset[LB_W-1:0] : end_q;
        wr_word_lsb = (idle ? bus.op_pkt_i.word_address[7:0] : waddr_q[7:0]) + wr_beat[7:0];
        wr_data     = pattern_word(wr_word_lsb);
    end

    byte_mask_gen #(.DATA_W(DATA_W)) u_wr_mask (
        .beat_i         (wr_beat),
        .n_i            (wr_n),
        .start_offset_i (wr_start),
        .end_offset_i   (wr_end),
        .byteenable_o   (wr_be)
    );

    byte_mask_gen #(.DATA_W(DATA_W)) u_rd_mask (
        .beat_i         (rd_cnt_q),
        .n_i            (n_q),
        .start_offset_i (start_q),
        .end_offset_i   (end_q),
        .byteenable_o   (rd_be)
    );

    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        start_d    = start_q;
        end_d      = end_q;
        n_d        = n_q;
        beat_d     = beat_q;
        rd_cnt_d   = rd_cnt_q;
        write_d    = write_q;
        read_d     = read_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_addr_d  = rd_addr_q;
        rd_be_d    = rd_be_q;

        case (state_q)
            IDLE_S: begin
                if (bus.op_valid_i) begin
                    waddr_d  = bus.op_pkt_i.word_address;
                    start_d  = bus.op_pkt_i.start_offset[LB_W-1:0];
                    end_d    = bus.op_pkt_i.end_offset[LB_W-1:0];
                    n_d      = acc_n;
                    beat_d   = '0;
                    rd_cnt_d = '0;
                    addr_d   = bus.op_pkt_i.word_address;
                    burst_d  = acc_n[AMM_BURST_W-1:0];
                    if (op_type_e'(bus.op_type_i) == OP_READ) begin
                        read_d  = 1'b1;
                        state_d = READ_CMD_S;
                    end else begin
                        write_d = 1'b1;
                        wdata_d = wr_data;
                        be_d    = wr_be;
                        state_d = WRITE_S;
                    end
                end
            end

            WRITE_S: begin
                if (!bus.amm_waitrequest_i) begin
                    if (beat_q == n_q - burst_len_t'(1)) begin
                        write_d = 1'b0;
                        state_d = IDLE_S;
                    end else begin
                        beat_d  = wr_beat;
                        wdata_d = wr_data;
                        be_d    = wr_be;
                    end
                end
            end

            READ_CMD_S, READ_DATA_S: begin
                if (state_q == READ_CMD_S && !bus.amm_waitrequest_i) begin
                    read_d  = 1'b0;
                    state_d = READ_DATA_S;
                end
                // Beats are counted from the command state too, so a fast slave cannot be missed.
                if (bus.amm_readdatavalid_i) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = bus.amm_readdata_i;
                    rd_addr_d  = waddr_q + AMM_ADDR_W'(rd_cnt_q);
                    rd_be_d    = rd_be;
                    rd_cnt_d   = rd_cnt_q + burst_len_t'(1);
                    if (rd_cnt_q == n_q - burst_len_t'(1)) begin
                        read_d  = 1'b0;
                        state_d = IDLE_S;
                    end
                end
            end

            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE_S;
            waddr_q    <= '0;
            start_q    <= '0;
            end_q      <= '0;
            n_q        <= '0;
            beat_q     <= '0;
            rd_cnt_q   <= '0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            addr_q     <= '0;
            burst_q    <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_be_q    <= '0;
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            start_q    <= start_d;
            end_q      <= end_d;
            n_q        <= n_d;
            beat_q     <= beat_d;
            rd_cnt_q   <= rd_cnt_d;
            write_q    <= write_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_be_q    <= rd_be_d;
        end
    end

    assign bus.cmd_accept_ready_o = idle;
    assign bus.trans_block_busy_o = !idle;
    assign bus.amm_address_o      = addr_q;
    assign bus.amm_write_o        = write_q;
    assign bus.amm_read_o         = read_q;
    assign bus.amm_writedata_o    = wdata_q;
    assign bus.amm_byteenable_o   = be_q;
    assign bus.amm_burstcount_o   = burst_q;
    assign bus.rd_data_valid_o    = rd_valid_q;
    assign bus.rd_data_o          = rd_data_q;
    assign bus.rd_addr_o          = rd_addr_q;
    assign bus.rd_byteenable_o    = rd_be_q;

endmodule

// File: doc/amm_trans_block.md
# amm_trans_block

Command consumer and Avalon-MM burst master of the memory checker. Accepts operation packets from the test controller over a valid/ready handshake and issues one Avalon-MM write or read burst per packet, with byte-accurate first/last-word byteenables. Write data is a deterministic address-derived pattern. Returned read beats are forwarded, tagged with address and byteenable, to the compare block.

## Interface
- AMM_DATA_W, settings_pkg value (64): Avalon data width, power of two ≥ 16
- AMM_ADDR_W, settings_pkg value (28): Avalon word-address width
- AMM_BURST_W, settings_pkg value (11): Avalon burstcount width
- BYTE_ADDR_W, $clog2(AMM_DATA_W/8): byte-in-word index width
- clk_i  in  1  single clock, all logic rising-edge
- rst_i  in  1  reset, asynchronous assert, active-low; synchronous deassert is the system's responsibility
- op_valid_i  in  1  command valid
- op_type_i  in  1  0 = write, 1 = read
- op_pkt_i  in  trans_struct_type  word_address, high_burst_bits, low_burst_bits, start_offset, end_offset
- cmd_accept_ready_o  out  1  command accepted on op_valid_i && cmd_accept_ready_o
- trans_block_busy_o  out  1  burst in progress or read beats outstanding
- amm_address_o  out  AMM_ADDR_W  burst start word address
- amm_write_o, amm_read_o  out  1 each  Avalon commands
- amm_writedata_o  out  AMM_DATA_W  pattern data
- amm_byteenable_o  out  AMM_DATA_W/8  lane enables
- amm_burstcount_o  out  AMM_BURST_W  burst length in words
- amm_waitrequest_i, amm_readdatavalid_i  in  1 each
- amm_readdata_i  in  AMM_DATA_W
- rd_data_valid_o  out  1  forwarded read beat valid
- rd_data_o  out  AMM_DATA_W  forwarded read data
- rd_addr_o  out  AMM_ADDR_W  word address of forwarded beat
- rd_byteenable_o  out  AMM_DATA_W/8  meaningful lanes of forwarded beat

## Operation
- States: IDLE_S, WRITE_S, READ_CMD_S, READ_DATA_S.
- cmd_accept_ready_o = (state == IDLE_S). On acceptance, the packet and op_type are registered. Next state is WRITE_S or READ_CMD_S.
- Burst length N = high_burst_bits + low_burst_bits, computed AMM_BURST_W+1 wide. N = 0 is treated as 1. The controller guarantees N < 2^AMM_BURST_W.
- Byteenable for beat b of N:
  - b = 0: lanes ≥ start_offset.
  - b = N−1: lanes ≤ end_offset.
  - N = 1: both conditions ANDed.
  - Otherwise: all ones.
- Write data: byte k of beat b = low 8 bits of ((word_address + b)·(AMM_DATA_W/8) + k).
- WRITE_S: amm_write_o = 1. Address and burstcount are held for the whole burst. Data/byteenable advance on each cycle with !amm_waitrequest_i. After the beat b = N−1 is accepted, go to IDLE_S.
- READ_CMD_S: amm_read_o = 1 until !amm_waitrequest_i, then go to READ_DATA_S.
- Beat counter: counts amm_readdatavalid_i in both READ_CMD_S and READ_DATA_S. After the Nth beat, go to IDLE_S.
- Each read beat is forwarded with rd_addr_o = word_address + beat index and rd_byteenable_o computed by the same mask rule.
- readdatavalid outside read states is ignored.
- trans_block_busy_o = (state != IDLE_S).

## Timing
- Reset values: all outputs 0, except cmd_accept_ready_o = 1 (IDLE_S). Reset mid-burst drops amm_write_o/amm_read_o immediately (asynchronous) and discards outstanding beats.
- Acceptance at edge T → amm_write_o or amm_read_o high in cycle T+1. Zero bubbles between consecutive accepted write beats.
- Last beat or last readdatavalid at edge T → cmd_accept_ready_o = 1 in T+1. Minimum command spacing: N+1 cycles (write) or read latency + 2 (read).
- Forwarded read beat: rd_* registered, 1-cycle latency after amm_readdatavalid_i.
- Avalon command signals are all registered. Under amm_waitrequest_i, address, burstcount, writedata and byteenable are held stable.

## Structure
- settings_pkg holds AMM_DATA_W, AMM_ADDR_W, AMM_BURST_W, BYTE_ADDR_W and trans_struct_type, shared with the controller and compare block.
- The state enum is local to the module.
- One sub-module, byte_mask_gen (combinational): inputs beat index, N, start_offset, end_offset; output byteenable. It is instantiated twice, once for writes and once for read forwarding.

## Test plan
All scenarios use AMM_DATA_W=32, BYTE_ADDR_W=2.
- Write, word_address=0x10, high=4, low=0, offsets 0/3, no waitrequest → 4 write beats in consecutive cycles. byteenable = 0xF each beat. writedata beat0 = 0x43424140, beat3 = 0x4F4E4D4C. Ready returns in cycle 5.
- Write, high=1, low=1, start_offset=2, end_offset=1 → burstcount = 2. byteenable 0xC then 0x3.
- Single-word write, start_offset=1, end_offset=2 → byteenable 0x6. Packet N = 0 → burstcount = 1.
- Write with waitrequest high for 3 cycles on beat 1 → address, data and byteenable held. Exactly 4 beats accepted.
- Read, N=3, readdatavalid 5 cycles after the command with one gap cycle → rd_data_valid_o ×3, rd_addr_o 0x10/0x11/0x12. Busy stays high until the third beat.
- rst_i low in the middle of a write burst → amm_write_o = 0 immediately, IDLE_S. The next accepted command runs normally.
